// File: rtl/control_fsm.sv
// Multicycle RV32I control unit: decodes the held instruction and walks it through
// IF/ID/EX/MEM/WB, driving datapath strobes as Moore decodes of state and instruction.
module control_fsm #(
    parameter logic [3:0] ALU_ADD = 4'b0010,
    parameter int         CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             Zero,
    output logic             PCSrc,
    output logic             ALUSrc,
    output logic [1:0]       ImmSel,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic [3:0]       ALUCtrl,
    output logic             loadPC,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             illegal_instr,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t cur, nxt;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal, is_r, is_i, is_lw, is_sw, is_beq;
    logic [3:0] dec_alu;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    assign unused_bits = ^{instr[24:15], instr[11:7]};

    // Instruction decode; kind flags are only raised for fully legal encodings.
    always_comb begin
        legal   = 1'b0;
        dec_alu = ALU_AND;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    legal = 1'b1;
                    case (funct3)
                        3'b000:  dec_alu = ALU_ADD;
                        3'b001:  dec_alu = ALU_SLL;
                        3'b010:  dec_alu = ALU_SLT;
                        3'b100:  dec_alu = ALU_XOR;
                        3'b101:  dec_alu = ALU_SRL;
                        3'b110:  dec_alu = ALU_OR;
                        3'b111:  dec_alu = ALU_AND;
                        default: legal   = 1'b0;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000) begin
                        legal   = 1'b1;
                        dec_alu = ALU_SUB;
                    end else if (funct3 == 3'b101) begin
                        legal   = 1'b1;
                        dec_alu = ALU_SRA;
                    end
                end
            end
            7'b0010011: begin
                legal = 1'b1;
                case (funct3)
                    3'b000: dec_alu = ALU_ADD;
                    3'b010: dec_alu = ALU_SLT;
                    3'b100: dec_alu = ALU_XOR;
                    3'b110: dec_alu = ALU_OR;
                    3'b111: dec_alu = ALU_AND;
                    3'b001: begin
                        dec_alu = ALU_SLL;
                        legal   = (funct7 == 7'b0000000);
                    end
                    3'b101: begin
                        dec_alu = funct7[5] ? ALU_SRA : ALU_SRL;
                        legal   = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    end
                    default: legal = 1'b0;
                endcase
            end
            7'b0000011: begin
                legal   = (funct3 == 3'b010);
                dec_alu = ALU_ADD;
            end
            7'b0100011: begin
                legal   = (funct3 == 3'b010);
                dec_alu = ALU_ADD;
            end
            7'b1100011: begin
                legal   = (funct3 == 3'b000);
                dec_alu = ALU_SUB;
            end
            default: legal = 1'b0;
        endcase
    end

    assign is_r   = legal && (opcode == 7'b0110011);
    assign is_i   = legal && (opcode == 7'b0010011);
    assign is_lw  = legal && (opcode == 7'b0000011);
    assign is_sw  = legal && (opcode == 7'b0100011);
    assign is_beq = legal && (opcode == 7'b1100011);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= S_IF;
            retired <= '0;
        end else begin
            cur <= nxt;
            if (cur == S_WB) retired <= retired + CNT_W'(1);
        end
    end

    // Next state and Moore outputs; rst forces every strobe low so an aborted
    // instruction never writes state.
    always_comb begin
        nxt           = cur;
        PCSrc         = 1'b0;
        ALUSrc        = 1'b0;
        ImmSel        = 2'b00;
        RegWrite      = 1'b0;
        MemToReg      = 1'b0;
        ALUCtrl       = 4'b0000;
        loadPC        = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        illegal_instr = 1'b0;
        case (cur)
            S_IF: nxt = S_ID;
            S_ID: begin
                if (legal) begin
                    nxt = S_EX;
                end else begin
                    nxt           = S_IF;
                    illegal_instr = 1'b1;
                end
            end
            S_EX: nxt = S_MEM;
            S_MEM: begin
                nxt      = S_WB;
                MemRead  = is_lw;
                MemWrite = is_sw;
            end
            S_WB: begin
                nxt      = S_IF;
                loadPC   = 1'b1;
                RegWrite = is_r || is_i || is_lw;
                MemToReg = is_lw;
                PCSrc    = is_beq && Zero;
            end
            default: nxt = S_IF;
        endcase
        if (cur == S_EX || cur == S_MEM || cur == S_WB) begin
            ALUCtrl = dec_alu;
            ALUSrc  = is_i || is_lw || is_sw;
            ImmSel  = is_sw ? 2'b01 : (is_beq ? 2'b10 : 2'b00);
        end
        if (rst) begin
            PCSrc         = 1'b0;
            ALUSrc        = 1'b0;
            ImmSel        = 2'b00;
            RegWrite      = 1'b0;
            MemToReg      = 1'b0;
            ALUCtrl       = 4'b0000;
            loadPC        = 1'b0;
            MemRead       = 1'b0;
            MemWrite      = 1'b0;
            illegal_instr = 1'b0;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: stimulus queues per-cycle expected output
// vectors; a negedge monitor pops one per cycle and compares against the DUT.
module tb_control_fsm;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      instr;
    logic             Zero;
    logic             PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, illegal_instr;
    logic [1:0]       ImmSel;
    logic [3:0]       ALUCtrl;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    control_fsm #(.ALU_ADD(4'b0010), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero),
        .PCSrc(PCSrc), .ALUSrc(ALUSrc), .ImmSel(ImmSel), .RegWrite(RegWrite),
        .MemToReg(MemToReg), .ALUCtrl(ALUCtrl), .loadPC(loadPC), .MemRead(MemRead),
        .MemWrite(MemWrite), .illegal_instr(illegal_instr), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [2:0]       st;
        logic             pcsrc, alusrc, regw, m2r, ldpc, mr, mw, ill;
        logic [1:0]       imm;
        logic [3:0]       alu;
        logic [CNT_W-1:0] ret;
    } exp_t;

    exp_t             sb[$];
    int               errors = 0;
    int               checks = 0;
    logic [CNT_W-1:0] exp_ret = '0;

    function automatic logic [20:0] pack_exp(input exp_t e);
        return {e.st, e.pcsrc, e.alusrc, e.imm, e.regw, e.m2r, e.alu,
                e.ldpc, e.mr, e.mw, e.ill, e.ret};
    endfunction

    function automatic exp_t blank(input string name, input logic [2:0] st);
        exp_t e;
        e.name = name; e.st = st; e.pcsrc = 0; e.alusrc = 0; e.regw = 0; e.m2r = 0;
        e.ldpc = 0; e.mr = 0; e.mw = 0; e.ill = 0; e.imm = 2'b00; e.alu = 4'b0000;
        e.ret = exp_ret;
        return e;
    endfunction

    // Monitor: one expected vector per cycle while the scoreboard holds entries.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t        e;
            logic [20:0] act, req;
            e   = sb.pop_front();
            act = {state, PCSrc, ALUSrc, ImmSel, RegWrite, MemToReg, ALUCtrl,
                   loadPC, MemRead, MemWrite, illegal_instr, retired};
            req = pack_exp(e);
            checks++;
            if (act !== req) begin
                errors++;
                $display("FAIL %s st%0d: got st=%0d pcs=%b asrc=%b imm=%b rw=%b m2r=%b alu=%b ldpc=%b mr=%b mw=%b ill=%b ret=%0d, need %h (got %h)",
                         e.name, e.st, state, PCSrc, ALUSrc, ImmSel, RegWrite, MemToReg, ALUCtrl,
                         loadPC, MemRead, MemWrite, illegal_instr, retired, req, act);
            end
        end
    end

    // Drive a legal instruction and queue the first n of its 5 per-state expectations.
    task automatic push_instr(input string name, input logic [31:0] ins, input logic z,
                              input logic [3:0] alu, input logic asrc, input logic [1:0] imm,
                              input logic mr, input logic mw, input logic rw, input logic m2r,
                              input logic pcs, input int n);
        instr = ins;
        Zero  = z;
        for (int s = 0; s < n; s++) begin
            exp_t e;
            e = blank(name, 3'(s));
            if (s >= 2) begin e.alu = alu; e.alusrc = asrc; e.imm = imm; end
            if (s == 3) begin e.mr = mr; e.mw = mw; end
            if (s == 4) begin e.regw = rw; e.m2r = m2r; e.pcsrc = pcs; e.ldpc = 1'b1; end
            sb.push_back(e);
        end
        if (n == 5) exp_ret = exp_ret + CNT_W'(1);
    endtask

    task automatic run_instr(input string name, input logic [31:0] ins, input logic z,
                             input logic [3:0] alu, input logic asrc, input logic [1:0] imm,
                             input logic mr, input logic mw, input logic rw, input logic m2r,
                             input logic pcs);
        push_instr(name, ins, z, alu, asrc, imm, mr, mw, rw, m2r, pcs, 5);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic run_illegal(input string name, input logic [31:0] ins);
        exp_t e;
        instr = ins;
        Zero  = 1'b0;
        sb.push_back(blank(name, 3'd0));
        e = blank(name, 3'd1);
        e.ill = 1'b1;
        sb.push_back(e);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        instr = 32'h0000_0013;
        Zero  = 1'b0;
        @(posedge clk); #1;
        sb.push_back(blank("reset", 3'd0));
        @(posedge clk); #1;
        sb.push_back(blank("reset", 3'd0));
        @(posedge clk); #1;
        rst = 1'b0;

        //        name      instr         Z  alu      asrc imm   mr mw rw m2r pcs
        run_instr("add",   32'h002081B3, 0, 4'b0010, 0, 2'b00, 0, 0, 1, 0, 0);
        run_instr("sub",   32'h402081B3, 0, 4'b0110, 0, 2'b00, 0, 0, 1, 0, 0);
        run_instr("lw",    32'h00812283, 0, 4'b0010, 1, 2'b00, 1, 0, 1, 1, 0);
        run_instr("sw",    32'h00512623, 0, 4'b0010, 1, 2'b01, 0, 1, 0, 0, 0);
        run_instr("beq_t", 32'h00208463, 1, 4'b0110, 0, 2'b10, 0, 0, 0, 0, 1);
        run_instr("beq_nt",32'h00208463, 0, 4'b0110, 0, 2'b10, 0, 0, 0, 0, 0);
        run_instr("xori",  32'h0040C093, 0, 4'b1101, 1, 2'b00, 0, 0, 1, 0, 0);
        run_instr("srai",  32'h4030D093, 0, 4'b1010, 1, 2'b00, 0, 0, 1, 0, 0);
        run_instr("sll",   32'h002091B3, 0, 4'b1001, 0, 2'b00, 0, 0, 1, 0, 0);
        run_instr("slt",   32'h0020A1B3, 0, 4'b0111, 0, 2'b00, 0, 0, 1, 0, 0);
        run_instr("and",   32'h0020F1B3, 0, 4'b0000, 0, 2'b00, 0, 0, 1, 0, 0);
        run_instr("add_z1",32'h002081B3, 1, 4'b0010, 0, 2'b00, 0, 0, 1, 0, 0);
        run_illegal("ill_ones", 32'hFFFFFFFF);
        run_illegal("ill_slli", 32'h40309093);
        run_illegal("ill_rf3",  32'h402091B3);

        // Abort an add in MEM: strobes drop immediately, FSM and counter clear.
        push_instr("abort", 32'h002081B3, 0, 4'b0010, 0, 2'b00, 0, 0, 1, 0, 0, 3);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.push_back(blank("abort_rst", 3'd3));
        @(posedge clk); #1;
        rst     = 1'b0;
        exp_ret = '0;

        // 2^CNT_W legal instructions wrap the counter back to zero.
        for (int k = 0; k < (1 << CNT_W); k++)
            run_instr("wrap", 32'h002081B3, 0, 4'b0010, 0, 2'b00, 0, 0, 1, 0, 0);
        run_illegal("after_wrap", 32'hFFFFFFFF);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, need 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
Multicycle control unit that drives the datapath's control inputs. It decodes the fetched 32-bit RV32I instruction, sequences it through IF/ID/EX/MEM/WB, and consumes the datapath's Zero flag to resolve branches. It also emits data-memory strobes, an immediate-select code, an illegal-instruction flag and a retired-instruction counter for verification.

Parameters:
- ALU_ADD, 4'b0010, ALUCtrl code for add. The other fixed codes are AND 0000, OR 0001, SUB 0110, SLT 0111, SRL 1000, SLL 1001, SRA 1010, XOR 1101.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  current instruction; upstream holds it stable from IF through WB.
- Zero  in  1  ALU zero flag from the datapath.
- PCSrc  out  1  1 = PC+branch offset, 0 = PC+4.
- ALUSrc  out  1  1 = immediate is ALU operand 2.
- ImmSel  out  2  00 = I, 01 = S, 10 = B immediate.
- RegWrite  out  1  register-file write enable.
- MemToReg  out  1  1 = write back dReadData.
- ALUCtrl  out  4  ALU operation.
- loadPC  out  1  PC update strobe.
- MemRead  out  1  data-memory read strobe.
- MemWrite  out  1  data-memory write strobe.
- illegal_instr  out  1  one-cycle pulse on an unsupported instruction.
- state  out  3  current state for debug: IF=0, ID=1, EX=2, MEM=3, WB=4.
- retired  out  CNT_W  count of completed legal instructions.

Behaviour:
- Reset:
  - state = IF, retired = 0.
  - All other outputs are 0, including ALUCtrl = 0000 and ImmSel = 00.
  - rst in any state aborts the instruction: no RegWrite, MemWrite or loadPC occurs that cycle.
- FSM: IF→ID→EX→MEM→WB→IF, unconditionally for legal instructions. Every legal instruction takes exactly 5 cycles.
- Illegal instruction (detected in ID):
  - ID→IF directly.
  - illegal_instr = 1 for the ID cycle only.
  - No strobes asserted, retired not incremented.
- Supported instructions:
  - R-type (opcode 0110011): add, sub, and, or, xor, sll, srl, sra, slt.
  - I-ALU (opcode 0010011): addi, andi, ori, xori, slti, slli, srli, srai.
  - LW (opcode 0000011, funct3 010).
  - SW (opcode 0100011, funct3 010).
  - BEQ (opcode 1100011, funct3 000).
  - Anything else is illegal, including:
    - R-type with funct7 other than 0000000/0100000, or 0100000 with funct3 other than 000/101;
    - slli/srli with funct7 ≠ 0000000, or srai with funct7 ≠ 0100000.
- ALUCtrl decode:
  - R-type: funct7[5]/funct3 select the op (sub when funct7[5]=1 and funct3=000; sra when funct7[5]=1 and funct3=101).
  - I-ALU: funct3 selects the op; funct7[5] picks srai over srli.
  - LW/SW: ALU_ADD.
  - BEQ: SUB.
  - ALUCtrl is driven in EX, MEM and WB; it is 0000 in IF and ID.
- ALUSrc / ImmSel, valid EX–WB, 0 otherwise:
  - I-ALU and LW: ALUSrc = 1, ImmSel = 00.
  - SW: ALUSrc = 1, ImmSel = 01.
  - BEQ: ALUSrc = 0, ImmSel = 10.
  - R-type: ALUSrc = 0, ImmSel = 00.
- MEM state:
  - MemRead = 1 for LW only.
  - MemWrite = 1 for SW only.
  - Each strobe is high for exactly one cycle.
- WB state:
  - loadPC = 1 for every legal instruction, exactly one cycle.
  - RegWrite = 1 for R-type, I-ALU and LW.
  - MemToReg = 1 for LW only.
  - PCSrc = 1 iff BEQ and Zero = 1, sampled combinationally in WB; otherwise 0.
- Output timing: all strobes are Moore-style decodes of state plus instr and are 0 outside their listed state. Only PCSrc depends on Zero.
- retired:
  - Increments by 1 on the WB→IF edge.
  - Wraps modulo 2^CNT_W.
  - rst takes priority over the increment.
- rd = x0: RegWrite still asserted; the register file ignores the write.

Test Plan:
1. rst held 2 cycles, then released → state = 0. All outputs 0 during reset; retired = 0.
2. instr = 0x002081B3 (add x3,x1,x2) → states 0,1,2,3,4,0. In WB: ALUCtrl = 0010, RegWrite = 1, loadPC = 1, MemToReg = 0. retired = 1 afterwards. Repeat with 0x402081B3 (sub): ALUCtrl = 0110.
3. instr = 0x00812283 (lw x5,8(x2)) → MEM: MemRead = 1, ALUSrc = 1, ImmSel = 00. WB: RegWrite = 1, MemToReg = 1. Then instr = 0x00512623 (sw x5,12(x2)) → MEM: MemWrite = 1, ImmSel = 01. WB: RegWrite = 0, loadPC = 1.
4. instr = 0x00208463 (beq x1,x2,+8):
   - Zero = 1 in WB → PCSrc = 1, loadPC = 1, ALUCtrl = 0110, ImmSel = 10.
   - Zero = 0 → PCSrc = 0.
5. instr = 0xFFFFFFFF → ID: illegal_instr = 1, next state = IF. No loadPC, retired unchanged.
6. Start add; assert rst during MEM → next cycle state = IF, no RegWrite/loadPC pulse, retired = 0. Preload retired to 0xFFFFFFFF, then complete one legal instruction → retired = 0 (wrap).
